// File: rtl/cpu_pkg.sv
// Shared CPU constants and the return-stack operation encoding.
package cpu_pkg;

  localparam int unsigned RS_DEPTH = 32;
  localparam int unsigned RS_PTR_W = 5;
  localparam int unsigned PC_W     = 8;

  // Stack operation requested by the core in a given cycle.
  typedef enum logic [1:0] {
    RS_NOP     = 2'b00,
    RS_POP     = 2'b01,
    RS_PUSH    = 2'b10,
    RS_REPLACE = 2'b11
  } rs_op_e;

  // Map the raw CALL/RET strobes onto a stack operation.
  function automatic rs_op_e rs_decode_op(input logic push, input logic pop);
    rs_op_e op;
    case ({push, pop})
      2'b10:   op = RS_PUSH;
      2'b01:   op = RS_POP;
      2'b11:   op = RS_REPLACE;
      default: op = RS_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rs_ptr_next.sv
// Next stack pointer / occupancy unit; all full/empty boundary gating lives here.
module rs_ptr_next
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = RS_DEPTH,
  parameter int unsigned PTR_W = RS_PTR_W
) (
  input  logic [PTR_W-1:0] sp,
  input  logic [PTR_W:0]   count,
  input  logic             push,
  input  logic             pop,
  output logic [PTR_W-1:0] sp_n,
  output logic [PTR_W:0]   count_n,
  output logic             wr_en,
  output logic [PTR_W-1:0] wr_idx,
  output logic             ovf_set,
  output logic             unf_set
);

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  logic   is_empty;
  logic   is_full;
  rs_op_e op;

  assign is_empty = (count == '0);
  assign is_full  = (count == CNT_FULL);
  assign op       = rs_decode_op(push, pop);

  // Resolve the requested operation against the current occupancy.
  always_comb begin
    sp_n    = sp;
    count_n = count;
    wr_en   = 1'b0;
    wr_idx  = sp;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    case (op)
      RS_PUSH: begin
        if (is_full) begin
          ovf_set = 1'b1;
        end else begin
          wr_en   = 1'b1;
          sp_n    = sp + PTR_W'(1);
          count_n = count + (PTR_W+1)'(1);
        end
      end
      RS_POP: begin
        if (is_empty) begin
          unf_set = 1'b1;
        end else begin
          sp_n    = sp - PTR_W'(1);
          count_n = count - (PTR_W+1)'(1);
        end
      end
      RS_REPLACE: begin
        wr_en = 1'b1;
        if (is_empty) begin
          // The pop half is illegal; the push half still lands in slot sp.
          unf_set = 1'b1;
          sp_n    = sp + PTR_W'(1);
          count_n = count + (PTR_W+1)'(1);
        end else begin
          wr_idx = sp - PTR_W'(1);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/return_stack.sv
// Return-address stack: LIFO storage, stack pointer, occupancy and sticky error flags.
module return_stack
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH  = RS_DEPTH,
  parameter int unsigned PTR_W  = RS_PTR_W,
  parameter int unsigned ADDR_W = PC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_addr,
  output logic [ADDR_W-1:0] top_addr,
  output logic [PTR_W-1:0]  sp,
  output logic [PTR_W:0]    count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  sp_q;
  logic [PTR_W-1:0]  sp_d;
  logic [PTR_W:0]    count_q;
  logic [PTR_W:0]    count_d;
  logic              ovf_q;
  logic              ovf_d;
  logic              unf_q;
  logic              unf_d;
  logic              wr_en;
  logic [PTR_W-1:0]  wr_idx;
  logic              ovf_set;
  logic              unf_set;

  rs_ptr_next #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ptr_next (
    .sp      (sp_q),
    .count   (count_q),
    .push    (push),
    .pop     (pop),
    .sp_n    (sp_d),
    .count_n (count_d),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .ovf_set (ovf_set),
    .unf_set (unf_set)
  );

  // Sticky error flags accumulate until reset.
  always_comb begin
    ovf_d = ovf_q | ovf_set;
    unf_d = unf_q | unf_set;
  end

  // Storage write; contents survive reset, but a write in a reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem_q[wr_idx] <= push_addr;
    end
  end

  // Pointer, occupancy and flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign top_addr  = mem_q[sp_q - PTR_W'(1)];
  assign sp        = sp_q;
  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_FULL);
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_return_stack.sv
// Self-checking bench for return_stack: queue-based LIFO model plus directed literal checks.
module tb_return_stack;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [7:0] push_addr = 8'h00;
  logic [7:0] top_addr;
  logic [4:0] sp;
  logic [5:0] count;
  logic       empty;
  logic       full;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int failures = 0;

  // Behavioural model: a queue whose back is the top of stack.
  logic [7:0] mq[$];
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;
  logic       m_valid = 1'b0;

  return_stack dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_addr (push_addr),
    .top_addr  (top_addr),
    .sp        (sp),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: just before each rising edge, check outputs then advance the model.
  always begin
    @(negedge clk);
    #4;
    if (m_valid) begin
      chk("m_count", 32'(count), 32'(mq.size()));
      chk("m_sp", 32'(sp), 32'(mq.size() % 32));
      chk("m_empty", 32'(empty), 32'(mq.size() == 0));
      chk("m_full", 32'(full), 32'(mq.size() == 32));
      chk("m_ovf", 32'(overflow), 32'(m_ovf));
      chk("m_unf", 32'(underflow), 32'(m_unf));
      if (mq.size() > 0) chk("m_top", 32'(top_addr), 32'(mq[mq.size()-1]));
    end
    if (reset) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (push && pop) begin
        if (mq.size() == 0) begin
          m_unf = 1'b1;
          mq.push_back(push_addr);
        end else begin
          mq[mq.size()-1] = push_addr;
        end
      end else if (push) begin
        if (mq.size() == 32) m_ovf = 1'b1;
        else mq.push_back(push_addr);
      end else if (pop) begin
        if (mq.size() == 0) m_unf = 1'b1;
        else void'(mq.pop_back());
      end
    end
  end

  // Drive one cycle of inputs; returns shortly after the falling edge.
  task automatic op(input logic r, input logic pu, input logic po, input logic [7:0] a);
    @(negedge clk);
    reset = r;
    push = pu;
    pop = po;
    push_addr = a;
    #1;
  endtask

  task automatic nop();
    op(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    // Reset state
    op(1'b1, 1'b0, 1'b0, 8'h00);
    nop();
    chk("rst_sp", 32'(sp), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);

    // Three pushes then three pops, top visible during each pop cycle
    op(1'b0, 1'b1, 1'b0, 8'h10);
    op(1'b0, 1'b1, 1'b0, 8'h20);
    op(1'b0, 1'b1, 1'b0, 8'h30);
    nop();
    chk("p3_sp", 32'(sp), 3);
    chk("p3_count", 32'(count), 3);
    chk("p3_top", 32'(top_addr), 32'h30);
    op(1'b0, 1'b0, 1'b1, 8'h00);
    chk("pop1_top", 32'(top_addr), 32'h30);
    op(1'b0, 1'b0, 1'b1, 8'h00);
    chk("pop2_top", 32'(top_addr), 32'h20);
    op(1'b0, 1'b0, 1'b1, 8'h00);
    chk("pop3_top", 32'(top_addr), 32'h10);
    nop();
    chk("pop3_empty", 32'(empty), 1);

    // Fill to full, then overflow
    for (int i = 0; i < 32; i++) op(1'b0, 1'b1, 1'b0, 8'(i));
    nop();
    chk("fill_full", 32'(full), 1);
    chk("fill_sp", 32'(sp), 0);
    chk("fill_top", 32'(top_addr), 32'h1F);
    op(1'b0, 1'b1, 1'b0, 8'hAA);
    nop();
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 32);
    chk("ovf_top", 32'(top_addr), 32'h1F);
    chk("ovf_full", 32'(full), 1);
    // Replace at full: no overflow growth, top replaced
    op(1'b0, 1'b1, 1'b1, 8'hBB);
    nop();
    chk("fullrep_top", 32'(top_addr), 32'hBB);
    chk("fullrep_count", 32'(count), 32);

    // Underflow from empty, then push
    op(1'b1, 1'b0, 1'b0, 8'h00);
    op(1'b0, 1'b0, 1'b1, 8'h00);
    nop();
    chk("unf_flag", 32'(underflow), 1);
    chk("unf_sp", 32'(sp), 0);
    chk("unf_count", 32'(count), 0);
    op(1'b0, 1'b1, 1'b0, 8'h55);
    nop();
    chk("unf_push_top", 32'(top_addr), 32'h55);
    chk("unf_push_count", 32'(count), 1);
    chk("unf_sticky", 32'(underflow), 1);

    // Replace top on a two-entry stack
    op(1'b1, 1'b0, 1'b0, 8'h00);
    op(1'b0, 1'b1, 1'b0, 8'h11);
    op(1'b0, 1'b1, 1'b0, 8'h22);
    op(1'b0, 1'b1, 1'b1, 8'h77);
    nop();
    chk("rep_count", 32'(count), 2);
    chk("rep_top", 32'(top_addr), 32'h77);
    chk("rep_unf", 32'(underflow), 0);
    op(1'b0, 1'b0, 1'b1, 8'h00);
    nop();
    chk("rep_pop_top", 32'(top_addr), 32'h11);

    // Push+pop while empty
    op(1'b1, 1'b0, 1'b0, 8'h00);
    op(1'b0, 1'b1, 1'b1, 8'h42);
    nop();
    chk("erep_unf", 32'(underflow), 1);
    chk("erep_count", 32'(count), 1);
    chk("erep_top", 32'(top_addr), 32'h42);

    // Build count=5 with both flags set, then reset together with a push
    op(1'b1, 1'b0, 1'b0, 8'h00);
    op(1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 33; i++) op(1'b0, 1'b1, 1'b0, 8'(8'h80 + i));
    for (int i = 0; i < 27; i++) op(1'b0, 1'b0, 1'b1, 8'h00);
    nop();
    chk("pre_count", 32'(count), 5);
    chk("pre_top", 32'(top_addr), 32'h84);
    chk("pre_ovf", 32'(overflow), 1);
    chk("pre_unf", 32'(underflow), 1);
    op(1'b1, 1'b1, 1'b0, 8'h99);
    nop();
    chk("rp_sp", 32'(sp), 0);
    chk("rp_count", 32'(count), 0);
    chk("rp_empty", 32'(empty), 1);
    chk("rp_ovf", 32'(overflow), 0);
    chk("rp_unf", 32'(underflow), 0);

    // A short mixed sequence checked by the model alone
    op(1'b0, 1'b1, 1'b0, 8'hC1);
    op(1'b0, 1'b1, 1'b1, 8'hC2);
    op(1'b0, 1'b1, 1'b0, 8'hC3);
    op(1'b0, 1'b0, 1'b1, 8'h00);
    op(1'b0, 1'b0, 1'b1, 8'h00);
    op(1'b0, 1'b0, 1'b1, 8'h00);
    nop();
    nop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/return_stack.md
Name: return_stack

Overview:
- Hardware return-address stack for the Harvard CPU.
- CALL pushes the return PC; RET pops it and presents it to the PC mux.
- Holds the registered stack pointer, the LIFO storage, occupancy flags and sticky error flags.
- Pointer arithmetic is next = sp + push - pop (5-bit, 32 entries), matching the CPU's 5-bit stack pointer convention.

Parameters:
- DEPTH, 32, number of entries; must be a power of two.
- PTR_W, 5, pointer width, log2(DEPTH).
- ADDR_W, 8, return-address width (program-counter width).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- push  input  1  CALL: write push_addr to the stack this cycle.
- pop  input  1  RET: remove the top entry this cycle.
- push_addr  input  ADDR_W  return address to store (PC+1 supplied by the core).
- top_addr  output  ADDR_W  current top-of-stack entry, combinational from storage; the PC mux uses it during the RET cycle.
- sp  output  PTR_W  registered stack pointer (index of next free slot).
- count  output  PTR_W+1  occupancy, 0..DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky: a push was attempted while full.
- underflow  output  1  sticky: a pop was attempted while empty.

Behaviour:
- Reset (synchronous, highest priority):
  - sp=0, count=0, empty=1, full=0, overflow=0, underflow=0.
  - Storage contents are not cleared.
  - top_addr is don't-care while empty; it is driven from mem[sp-1 mod DEPTH].
  - Reset asserted together with push/pop: reset wins and the operation is dropped.
- Stack grows upward. sp points to the next free slot, and top is mem[sp-1].
- Push only, not full:
  - mem[sp] <= push_addr; sp <= sp+1; count+1.
  - The new top is visible on top_addr the next cycle (1-cycle latency).
- Pop only, not empty:
  - top_addr is valid in the same cycle as pop (0-cycle read); the core samples it that cycle.
  - sp <= sp-1; count-1.
- Push and pop together, not empty:
  - Replace top: mem[sp-1] <= push_addr.
  - sp and count unchanged.
- Push and pop together, empty:
  - underflow <= 1.
  - The push is performed as push-only: mem[0] <= push_addr, sp=1, count=1.
- Push while full (without pop):
  - No write; sp and count unchanged; overflow <= 1.
  - full and top_addr stay stable.
- Push and pop while full: treated as replace-top; no overflow.
- Pop while empty (without push): no change; underflow <= 1.
- Wrap-around:
  - sp is modulo DEPTH, so at full, sp == 0 again.
  - count disambiguates full from empty; sp alone never determines the flags.
- Sticky flags clear only on reset.
- empty and full are decoded from registered count; they are not registered separately and change in the cycle after the causing operation.
- Storage is a DEPTH x ADDR_W register array: synchronous write, asynchronous read.

State machine (status FSM on count):
- EMPTY -> PARTIAL on push.
- PARTIAL -> EMPTY on pop at count=1.
- PARTIAL -> FULL on push at count=DEPTH-1.
- FULL -> PARTIAL on pop.
- Illegal operations cause no transition and set the sticky flag.
- State is encoded implicitly by count; no separate state register.

Decomposition:
- Shared package cpu_pkg holds:
  - RS_DEPTH=32, RS_PTR_W=5, PC_W=8;
  - an enum for stack op {RS_NOP, RS_PUSH, RS_POP, RS_REPLACE} derived from {push,pop}.
- One natural sub-module: rs_ptr_next, the combinational next-pointer/next-count unit.
  - Inputs: sp, count, push, pop.
  - Outputs: sp_n, count_n, wr_en, wr_idx, ovf_set, unf_set.
  - It keeps all boundary gating in one testable block.
- The storage array and registers stay in return_stack.

Test Plan:
- Reset, then 3 pushes (0x10, 0x20, 0x30) -> sp=3, count=3, top_addr=0x30; 3 pops return 0x30, 0x20, 0x10 in the pop cycle; then empty=1.
- 32 pushes of 0x00..0x1F -> full=1, sp=0, top_addr=0x1F; a 33rd push of 0xAA -> overflow=1, count=32, top_addr still 0x1F.
- From empty, pop -> underflow=1, sp=0, count=0; then push 0x55 -> top_addr=0x55, count=1, underflow stays 1.
- Stack holding [0x11, 0x22]; push=pop=1 with push_addr=0x77 -> count=2, top_addr=0x77; a following pop exposes 0x11.
- From empty, push=pop=1 with push_addr=0x42 -> underflow=1, count=1, top_addr=0x42.
- Stack with count=5 and both flags set; reset asserted in the same cycle as a push -> next cycle sp=0, count=0, empty=1, overflow=0, underflow=0.
